// File: rtl/encode_pkg.sv
// rtl/encode_pkg.sv - shared types, zigzag table and code constants for the block entropy coder
package encode_pkg;

  localparam int N_COEF = 64;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 512;
  localparam int PTR_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH,
    DONE
  } state_t;

  localparam logic       ZERO      = 1'b0;
  localparam logic [1:0] NZ_PREFIX = 2'b10;
  localparam logic [1:0] EOB       = 2'b11;

  // Row-major index (8r+c) of each zigzag position.
  localparam logic [5:0] ZIGZAG [0:N_COEF-1] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [COEF_W-1:0] coef_at(input logic [OUT_W-1:0] blk,
                                                input logic [5:0] idx);
    return blk[(10'(6'd63 - idx) << 3) +: COEF_W];
  endfunction

endpackage

// File: rtl/encode_vlc.sv
// rtl/encode_vlc.sv - combinational code generator for one coefficient, code left-aligned in 13 bits
module encode_vlc
  import encode_pkg::*;
(
  input  logic [COEF_W-1:0] v,
  output logic [3:0]        len,
  output logic [12:0]       code
);

  logic [8:0] mag;
  logic [8:0] vm1;
  logic [3:0] s;
  logic [7:0] mask;
  logic [7:0] vbits;
  logic [7:0] aligned;

  always_comb begin
    // Nine bits so that |-128| is representable.
    mag = v[7] ? (9'd0 - {1'b1, v}) : {1'b0, v};
    s = 4'd0;
    for (int b = 0; b < 8; b++) begin
      if (mag[b]) s = 4'(b + 1);
    end
    vm1     = {v[7], v} - 9'd1;
    vbits   = v[7] ? vm1[7:0] : v;
    mask    = 8'((9'd1 << s) - 9'd1);
    aligned = 8'((vbits & mask) << (4'd8 - s));
    if (v != '0) begin
      len  = 4'd5 + s;
      code = {NZ_PREFIX, 3'(s - 4'd1), aligned};
    end else begin
      len  = 4'd1;
      code = {ZERO, 12'd0};
    end
  end

endmodule

// File: rtl/encode.sv
// rtl/encode.sv - zigzag entropy coder for one 8x8 block, bit-packed MSB-first into a 512-bit stream
module encode
  import encode_pkg::*;
(
  input  logic             Clock,
  input  logic             reset,
  input  logic             Enable,
  input  logic [OUT_W-1:0] A,
  output logic [OUT_W-1:0] C,
  output logic             done
);

  state_t           state_q, state_d;
  logic [OUT_W-1:0] a_q, a_d;
  logic [OUT_W-1:0] c_q, c_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [5:0]       k_q, k_d;
  logic [6:0]       eob_q, eob_d;
  logic             done_q, done_d;

  logic [6:0]  eob_new;
  logic [3:0]  vlc_len;
  logic [12:0] vlc_code;
  logic [3:0]  emit_len;
  logic [12:0] emit_code;
  logic [10:0] pos;
  logic [10:0] sum;

  // eob_new is L+1: the zigzag step where EOB goes (0 for an all-zero block, 64 means FLUSH).
  always_comb begin
    eob_new = 7'd0;
    for (int k = 0; k < N_COEF; k++) begin
      if (coef_at(A, ZIGZAG[k]) != '0) eob_new = 7'(k + 1);
    end
  end

  encode_vlc u_vlc (
    .v    (coef_at(a_q, ZIGZAG[k_q])),
    .len  (vlc_len),
    .code (vlc_code)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    c_d       = c_q;
    ptr_d     = ptr_q;
    k_d       = k_q;
    eob_d     = eob_q;
    done_d    = done_q;
    emit_len  = 4'd0;
    emit_code = 13'd0;
    pos       = 11'd0;
    sum       = 11'd0;

    case (state_q)
      IDLE: begin
        if (Enable) begin
          a_d     = A;
          c_d     = '0;
          ptr_d   = '0;
          k_d     = 6'd0;
          eob_d   = eob_new;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!Enable) begin
          state_d = IDLE;
        end else begin
          if ({1'b0, k_q} < eob_q) begin
            emit_len  = vlc_len;
            emit_code = vlc_code;
          end else if ({1'b0, k_q} == eob_q) begin
            emit_len  = 4'd2;
            emit_code = {EOB, 11'd0};
          end
          k_d = k_q + 6'd1;
          if (k_q == 6'd63) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!Enable) begin
          state_d = IDLE;
        end else begin
          if (eob_q == 7'd64) begin
            emit_len  = 4'd2;
            emit_code = {EOB, 11'd0};
          end
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!Enable) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bits landing at or past position 512 are silently dropped.
    if (emit_len != 4'd0) begin
      for (int i = 0; i < 13; i++) begin
        pos = 11'(ptr_q) + 11'(i);
        if ((4'(i) < emit_len) && (pos < 11'd512)) c_d[9'(11'd511 - pos)] = emit_code[12-i];
      end
      sum   = 11'(ptr_q) + 11'(emit_len);
      ptr_d = (sum > 11'd512) ? 10'd512 : sum[PTR_W-1:0];
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      c_q     <= '0;
      ptr_q   <= '0;
      k_q     <= '0;
      eob_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      c_q     <= c_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
      eob_q   <= eob_d;
      done_q  <= done_d;
    end
  end

  assign C    = c_q;
  assign done = done_q;

endmodule

// File: tb/tb_encode.sv
// tb/tb_encode.sv - randomized self-checking bench for encode against a queue-based stream model
module tb_encode;

  logic         Clock = 1'b0;
  logic         reset;
  logic         Enable;
  logic [511:0] A;
  logic [511:0] C;
  logic         done;

  int checks = 0;
  int errors = 0;
  int zz[64];

  encode dut (
    .Clock  (Clock),
    .reset  (reset),
    .Enable (Enable),
    .A      (A),
    .C      (C),
    .done   (done)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int coef(input logic [511:0] blk, input int r, input int c);
    logic [7:0] b;
    b = blk[(63 - (8*r + c))*8 +: 8];
    return int'($signed(b));
  endfunction

  function automatic logic [511:0] put(input logic [511:0] blk, input int r, input int c, input int v);
    logic [511:0] t;
    t = blk;
    t[(63 - (8*r + c))*8 +: 8] = 8'(v);
    return t;
  endfunction

  // Steps 0..63 are zigzag positions, step 64 is the flush step.
  function automatic logic [511:0] model(input logic [511:0] blk, input int nsteps);
    int vals[64];
    int last;
    int v, mag, s, bits;
    bit q[$];
    logic [511:0] out;
    last = -1;
    out = '0;
    for (int k = 0; k < 64; k++) begin
      vals[k] = coef(blk, zz[k] / 8, zz[k] % 8);
      if (vals[k] != 0) last = k;
    end
    for (int step = 0; step < nsteps; step++) begin
      if (step < 64) begin
        if (step <= last) begin
          v = vals[step];
          if (v == 0) begin
            q.push_back(1'b0);
          end else begin
            mag = (v < 0) ? -v : v;
            s = 0;
            while ((1 << s) <= mag) s++;
            q.push_back(1'b1);
            q.push_back(1'b0);
            for (int b = 2; b >= 0; b--) q.push_back(bit'(((s - 1) >> b) & 1));
            bits = (v > 0) ? v : v + (1 << s) - 1;
            for (int b = s - 1; b >= 0; b--) q.push_back(bit'((bits >> b) & 1));
          end
        end else if (step == last + 1) begin
          q.push_back(1'b1);
          q.push_back(1'b1);
        end
      end else if (last == 63) begin
        q.push_back(1'b1);
        q.push_back(1'b1);
      end
    end
    for (int i = 0; i < q.size() && i < 512; i++) out[511 - i] = q[i];
    return out;
  endfunction

  function automatic logic [511:0] rand_block(input int density);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 64; i++) begin
      if (int'($urandom_range(99)) < density) b[i*8 +: 8] = 8'($urandom);
    end
    return b;
  endfunction

  task automatic run_block(input string tag, input logic [511:0] blk, input bit scramble);
    int cnt;
    logic [511:0] exp;
    cnt = 0;
    exp = model(blk, 65);
    A = blk;
    Enable = 1'b1;
    while (cnt < 200) begin
      @(posedge Clock);
      #1;
      cnt++;
      if (scramble && cnt == 1) A = {16{$urandom}};
      if (done) break;
    end
    check({tag, "_latency"}, 512'(cnt), 512'd66);
    check({tag, "_C"}, C, exp);
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check({tag, "_done_clr"}, 512'(done), 512'd0);
    check({tag, "_C_hold"}, C, exp);
  endtask

  initial begin
    int idx;
    int seen;
    logic [511:0] blk;
    logic [511:0] exp;

    idx = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz[idx] = 8*r + (s - r);
          idx++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz[idx] = 8*r + (s - r);
          idx++;
        end
      end
    end

    reset = 1'b0;
    Enable = 1'b0;
    A = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_C", C, 512'd0);
    check("reset_done", 512'(done), 512'd0);
    reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check("idle_done", 512'(done), 512'd0);

    run_block("zero", 512'd0, 1'b0);
    check("zero_const", C, {8'hC0, 504'd0});

    run_block("dc9", put(512'd0, 0, 0, 9), 1'b0);
    check("dc9_const", C, {16'h9CE0, 496'd0});

    run_block("dcm1", put(512'd0, 0, 0, -1), 1'b0);
    check("dcm1_const", C, {8'h83, 504'd0});

    blk = '0;
    blk = put(blk, 0, 0, 9);  blk = put(blk, 0, 1, 3);  blk = put(blk, 0, 2, 1);
    blk = put(blk, 0, 3, 4);  blk = put(blk, 0, 4, 1);  blk = put(blk, 0, 6, -1);
    blk = put(blk, 1, 0, 2);  blk = put(blk, 1, 1, 8);  blk = put(blk, 1, 3, 1);
    blk = put(blk, 1, 4, 1);  blk = put(blk, 2, 0, -6); blk = put(blk, 2, 1, -4);
    blk = put(blk, 2, 3, -1); blk = put(blk, 3, 0, -2); blk = put(blk, 3, 1, -4);
    blk = put(blk, 4, 0, -1);
    run_block("full", blk, 1'b1);

    run_block("sat128", {64{8'h80}}, 1'b0);
    run_block("last77", put(512'd0, 7, 7, 5), 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_block($sformatf("rand%0d", i), rand_block(5 + i * 10), 1'b1);
    end

    // Done handshake: hold Enable after completion.
    blk = rand_block(30);
    exp = model(blk, 65);
    A = blk;
    Enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge Clock);
      #1;
    end
    repeat (6) begin
      @(posedge Clock);
      #1;
      if (!done) seen++;
    end
    check("hold_done", 512'(seen), 512'd0);
    check("hold_C", C, exp);
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check("hold_done_clr", 512'(done), 512'd0);
    check("hold_C_after", C, exp);

    // Abort mid-scan: capture edge plus 19 scan steps, then Enable drops.
    blk = rand_block(70);
    A = blk;
    Enable = 1'b1;
    repeat (20) @(posedge Clock);
    #1;
    Enable = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge Clock);
      #1;
      if (done) seen++;
    end
    check("abort_done", 512'(seen), 512'd0);
    check("abort_C", C, model(blk, 19));
    run_block("after_abort", rand_block(40), 1'b0);

    // Asynchronous reset mid-scan.
    A = rand_block(80);
    Enable = 1'b1;
    repeat (30) @(posedge Clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_C", C, 512'd0);
    check("async_rst_done", 512'(done), 512'd0);
    Enable = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge Clock);
    #1;
    run_block("after_reset", rand_block(50), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
